// File: rtl/prbs_pkg.sv
// Shared definitions for the degree-7 PRBS generator/checker pair.
package prbs_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } prbs_state_e;

    localparam int PRBS_DEGREE   = 7;
    localparam int PRBS_TAP      = 1;
    localparam int ERR_CNT_WIDTH = 16;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/prbs_sat_cnt.sv
// Saturating up-counter: holds at all-ones until cleared.
module prbs_sat_cnt
    import prbs_pkg::*;
#(
    parameter int WIDTH = ERR_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             sat
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS checker: hunts for lock on the received stream,
// then counts bit errors against the predicted sequence and drops lock on bursts.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int DEGREE      = PRBS_DEGREE,
    parameter int TAP         = PRBS_TAP,
    parameter int LOCK_CNT    = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_WIDTH   = ERR_CNT_WIDTH
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RBI,
    input  logic                 InValid_SI,
    input  logic                 InBit_DI,
    input  logic                 Clear_SI,
    output logic                 Locked_SO,
    output logic                 BitErr_SO,
    output logic [CNT_WIDTH-1:0] ErrCnt_DO,
    output logic                 ErrSat_SO
);

    localparam int FILL_W  = $clog2(DEGREE + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(DEGREE);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THRESH - 1);

    prbs_state_e        state, state_nxt;
    logic [DEGREE-1:0]  hist;
    logic [FILL_W-1:0]  fill_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [WERR_W-1:0]  win_err;
    logic               bit_err_p1;

    logic accept;
    logic pred;
    logic mismatch;
    logic hunt_match;
    logic lock_hit;
    logic lock_err;
    logic loss_hit;
    logic win_wrap;

    // Stage 0: prediction and compare on the accepted bit
    always_comb begin
        accept     = InValid_SI & ~Clear_SI;
        pred       = hist[DEGREE-1] ^ hist[DEGREE-1-TAP];
        mismatch   = InBit_DI ^ pred;
        // an all-zero history predicts zeros forever, so it never counts as a match
        hunt_match = accept && (state == HUNT) && (fill_cnt == FILL_FULL)
                     && !mismatch && (hist != '0);
        lock_hit   = hunt_match && (match_cnt == MATCH_LAST);
        lock_err   = accept && (state == LOCKED) && mismatch;
        loss_hit   = lock_err && (win_err == WERR_LAST);
        win_wrap   = (win_cnt == WIN_LAST);
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (Clear_SI) begin
            state_nxt = HUNT;
        end else if ((state == HUNT) && lock_hit) begin
            state_nxt = LOCKED;
        end else if ((state == LOCKED) && loss_hit) begin
            state_nxt = HUNT;
        end
    end

    always_comb begin
        Locked_SO = (state == LOCKED);
        BitErr_SO = bit_err_p1;
    end

    // Stage 1: history, hunt and window bookkeeping
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            hist       <= '0;
            fill_cnt   <= '0;
            match_cnt  <= '0;
            win_cnt    <= '0;
            win_err    <= '0;
            bit_err_p1 <= 1'b0;
        end else if (Clear_SI) begin
            fill_cnt   <= '0;
            match_cnt  <= '0;
            win_cnt    <= '0;
            win_err    <= '0;
            bit_err_p1 <= 1'b0;
        end else begin
            bit_err_p1 <= lock_err;
            if (accept) begin
                if (state == HUNT) begin
                    hist <= {hist[DEGREE-2:0], InBit_DI};
                    if (fill_cnt != FILL_FULL) begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end else if (hunt_match && !lock_hit) begin
                        match_cnt <= match_cnt + 1'b1;
                    end else begin
                        match_cnt <= '0;
                    end
                end else begin
                    // shifting the prediction keeps one corrupted bit from poisoning later predictions
                    hist <= {hist[DEGREE-2:0], pred};
                    if (loss_hit) begin
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                        win_cnt   <= '0;
                        win_err   <= '0;
                    end else if (win_wrap) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                        if (lock_err) begin
                            win_err <= win_err + 1'b1;
                        end
                    end
                end
            end
        end
    end

    prbs_sat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk   (Clk_CI),
        .rst_n (Rst_RBI),
        .clr   (Clear_SI),
        .inc   (lock_err),
        .cnt   (ErrCnt_DO),
        .sat   (ErrSat_SO)
    );

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: a 16-bit and a 4-bit counter instance share one stimulus stream.
module tb_prbs7_checker;

    localparam int DEGREE      = 7;
    localparam int TAP         = 1;
    localparam int LOCK_CNT    = 16;
    localparam int WINDOW      = 64;
    localparam int LOSS_THRESH = 8;
    localparam int MAX_A       = 65535;
    localparam int MAX_B       = 15;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit   = 1'b0;
    logic clear    = 1'b0;

    logic        locked_a, bit_err_a, err_sat_a;
    logic [15:0] err_cnt_a;
    logic        locked_b, bit_err_b, err_sat_b;
    logic [3:0]  err_cnt_b;

    always #5 clk = ~clk;

    prbs7_checker #(.CNT_WIDTH(16)) dut_a (
        .Clk_CI     (clk),
        .Rst_RBI    (rst_n),
        .InValid_SI (in_valid),
        .InBit_DI   (in_bit),
        .Clear_SI   (clear),
        .Locked_SO  (locked_a),
        .BitErr_SO  (bit_err_a),
        .ErrCnt_DO  (err_cnt_a),
        .ErrSat_SO  (err_sat_a)
    );

    prbs7_checker #(.CNT_WIDTH(4)) dut_b (
        .Clk_CI     (clk),
        .Rst_RBI    (rst_n),
        .InValid_SI (in_valid),
        .InBit_DI   (in_bit),
        .Clear_SI   (clear),
        .Locked_SO  (locked_b),
        .BitErr_SO  (bit_err_b),
        .ErrCnt_DO  (err_cnt_b),
        .ErrSat_SO  (err_sat_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: stream-level rules with the last DEGREE bits kept oldest-first.
    bit m_hist[$];
    bit m_locked, m_biterr;
    int m_fill, m_match, m_win_idx, m_win_err, m_err;

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < DEGREE; i++) m_hist.push_back(1'b0);
        m_locked = 0; m_biterr = 0; m_fill = 0; m_match = 0;
        m_win_idx = 0; m_win_err = 0; m_err = 0;
    endfunction

    function automatic void model_clock(bit v, bit b, bit c);
        bit pred;
        bit any_one;
        m_biterr = 0;
        if (c) begin
            m_locked = 0; m_fill = 0; m_match = 0;
            m_win_idx = 0; m_win_err = 0; m_err = 0;
            return;
        end
        if (!v) return;
        pred = m_hist[0] ^ m_hist[TAP];
        any_one = 0;
        for (int i = 0; i < DEGREE; i++) any_one |= m_hist[i];
        if (!m_locked) begin
            if (m_fill < DEGREE) m_fill++;
            else if (b == pred && any_one) begin
                m_match++;
                if (m_match == LOCK_CNT) begin
                    m_locked = 1; m_match = 0; m_win_idx = 0; m_win_err = 0;
                end
            end else m_match = 0;
            m_hist.push_back(b);
        end else begin
            m_hist.push_back(pred);
            if (b != pred) begin
                m_biterr = 1; m_err++; m_win_err++;
            end
            if (m_win_err >= LOSS_THRESH) begin
                m_locked = 0; m_fill = 0; m_match = 0; m_win_idx = 0; m_win_err = 0;
            end else begin
                m_win_idx++;
                if (m_win_idx == WINDOW) begin
                    m_win_idx = 0; m_win_err = 0;
                end
            end
        end
        void'(m_hist.pop_front());
    endfunction

    task automatic compare_all();
        chk("locked_a",  int'(locked_a),  int'(m_locked));
        chk("bit_err_a", int'(bit_err_a), int'(m_biterr));
        chk("err_cnt_a", int'(err_cnt_a), (m_err > MAX_A) ? MAX_A : m_err);
        chk("err_sat_a", int'(err_sat_a), (m_err >= MAX_A) ? 1 : 0);
        chk("locked_b",  int'(locked_b),  int'(m_locked));
        chk("bit_err_b", int'(bit_err_b), int'(m_biterr));
        chk("err_cnt_b", int'(err_cnt_b), (m_err > MAX_B) ? MAX_B : m_err);
        chk("err_sat_b", int'(err_sat_b), (m_err >= MAX_B) ? 1 : 0);
    endtask

    // PRBS7 source: seed 1,0,0,0,0,0,0 then b[n] = b[n-7] ^ b[n-6]
    bit g_seq[$];
    int g_n;

    function automatic void gen_reset();
        g_seq.delete();
        g_n = 0;
    endfunction

    function automatic bit gen_next();
        bit b;
        if (g_n < DEGREE) b = (g_n == 0);
        else b = g_seq[0] ^ g_seq[TAP];
        g_seq.push_back(b);
        if (g_seq.size() > DEGREE) void'(g_seq.pop_front());
        g_n++;
        return b;
    endfunction

    task automatic step(input bit v, input bit b, input bit c);
        in_valid = v; in_bit = b; clear = c;
        @(posedge clk);
        model_clock(v, b, c);
        #1;
        compare_all();
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic send(input bit flip);
        bit gb;
        gb = gen_next();
        step(1'b1, gb ^ flip, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; clear = 1'b0; in_bit = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit v;
        bit b;
        bit c;
        bit exp_locked;
        bit exp_bit_err;
        int exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(bit v, bit b, bit c, bit el, bit eb, int ec);
        vec_t t;
        t.v = v; t.b = b; t.c = c; t.exp_locked = el; t.exp_bit_err = eb; t.exp_cnt = ec;
        vecs.push_back(t);
    endfunction

    initial begin
        logic [15:0] tail;
        int accepted, lock_at, pulses;
        bit locked_seen;

        // Vectors from reset: seed, 16 predicted bits (lock on the 23rd), one error, clear.
        tail = 16'b1000_0011_0000_1010;
        for (int i = 0; i < 3; i++) add_vec(0, 0, 0, 0, 0, 0);
        add_vec(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add_vec(1, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add_vec(1, tail[15-i], 0, (i == 15), 0, 0);
        add_vec(0, 0, 0, 1, 0, 0);
        add_vec(1, 1, 0, 1, 1, 1);
        add_vec(0, 0, 0, 1, 0, 1);
        add_vec(1, 1, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0);

        // Reset with idle input: everything stays low.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("rst_idle_locked", int'(locked_a), 0);
            chk("rst_idle_cnt", int'(err_cnt_a), 0);
        end

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].b, vecs[i].c);
            chk("vec_locked", int'(locked_a), int'(vecs[i].exp_locked));
            chk("vec_bit_err", int'(bit_err_a), int'(vecs[i].exp_bit_err));
            chk("vec_err_cnt", int'(err_cnt_a), vecs[i].exp_cnt);
            chk("vec_err_cnt_b", int'(err_cnt_b), vecs[i].exp_cnt);
        end

        // Clean stream: lock on the 23rd accepted bit, then no errors.
        do_reset();
        gen_reset();
        for (int i = 1; i <= 23; i++) begin
            send(1'b0);
            if (i == 22) chk("lock_pre_23", int'(locked_a), 0);
            if (i == 23) chk("lock_at_23", int'(locked_a), 1);
        end
        for (int i = 0; i < 254; i++) send(1'b0);
        chk("clean_err_cnt", int'(err_cnt_a), 0);
        chk("clean_locked", int'(locked_a), 1);

        // Same lock point in accepted bits with random gaps.
        do_reset();
        gen_reset();
        accepted = 0;
        lock_at = -1;
        for (int i = 0; i < 400 && !(lock_at > 0 && accepted >= 30); i++) begin
            if ($urandom_range(2) == 0) begin
                step(1'b0, 1'(($urandom_range(1))), 1'b0);
            end else begin
                send(1'b0);
                accepted++;
                if (locked_a && lock_at < 0) lock_at = accepted;
            end
        end
        chk("gap_lock_point", lock_at, 23);

        // Single flipped bit counts once; a second flip 30 bits later.
        send(1'b1);
        chk("flip1_bit_err", int'(bit_err_a), 1);
        chk("flip1_err_cnt", int'(err_cnt_a), 1);
        chk("flip1_locked", int'(locked_a), 1);
        pulses = 0;
        step(1'b0, 1'b0, 1'b0);
        pulses += int'(bit_err_a);
        for (int i = 0; i < 29; i++) begin
            send(1'b0);
            pulses += int'(bit_err_a);
        end
        chk("flip1_extra_pulses", pulses, 0);
        send(1'b1);
        chk("flip2_err_cnt", int'(err_cnt_a), 2);
        chk("flip2_locked", int'(locked_a), 1);

        // Constant streams never lock.
        step(1'b0, 1'b0, 1'b1);
        locked_seen = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b0);
            locked_seen |= locked_a;
        end
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 1'b0);
            locked_seen |= locked_a;
        end
        chk("const_never_locked", int'(locked_seen), 0);
        chk("const_err_cnt", int'(err_cnt_a), 0);

        // Relock after a clear, then a burst of 8 errors in one window.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 23; i++) send(1'b0);
        chk("relock_after_const", int'(locked_a), 1);
        for (int k = 0; k < LOSS_THRESH; k++) begin
            if (k == LOSS_THRESH - 1) chk("loss_pre", int'(locked_a), 1);
            send(1'b1);
            if (k < LOSS_THRESH - 1) repeat (4) send(1'b0);
        end
        chk("loss_locked", int'(locked_a), 0);
        chk("loss_err_cnt", int'(err_cnt_a), 8);
        for (int i = 1; i <= 23; i++) begin
            send(1'b0);
            if (i == 22) chk("relock_pre", int'(locked_a), 0);
        end
        chk("relock_locked", int'(locked_a), 1);
        chk("relock_err_cnt", int'(err_cnt_a), 8);

        // Seven errors per window over three windows: lock holds, 4-bit count saturates.
        for (int i = 0; i < 3 * WINDOW; i++) begin
            send(((m_win_idx % 9) == 2) && (m_win_idx <= 56));
        end
        chk("w7_locked", int'(locked_a), 1);
        chk("w7_err_cnt_a", int'(err_cnt_a), 29);
        chk("w7_err_sat_a", int'(err_sat_a), 0);
        chk("w7_err_cnt_b", int'(err_cnt_b), 15);
        chk("w7_err_sat_b", int'(err_sat_b), 1);
        send(1'b1);
        chk("sat_bit_err_b", int'(bit_err_b), 1);
        chk("sat_hold_b", int'(err_cnt_b), 15);

        // Clear with a valid bit: counters zeroed and the bit is discarded.
        begin
            bit gb;
            gb = gen_next();
            step(1'b1, gb, 1'b1);
        end
        chk("clr_err_cnt", int'(err_cnt_a), 0);
        chk("clr_locked", int'(locked_a), 0);
        chk("clr_bit_err", int'(bit_err_a), 0);
        chk("clr_err_sat_b", int'(err_sat_b), 0);
        for (int i = 1; i <= 23; i++) begin
            send(1'b0);
            if (i == 22) chk("clr_discard_pre", int'(locked_a), 0);
        end
        chk("clr_discard_lock", int'(locked_a), 1);

        // Asynchronous reset while a bit-error pulse is high.
        send(1'b1);
        chk("mid_bit_err_high", int'(bit_err_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_locked", int'(locked_a), 0);
        chk("mid_rst_bit_err", int'(bit_err_a), 0);
        chk("mid_rst_err_cnt", int'(err_cnt_a), 0);
        chk("mid_rst_err_sat_b", int'(err_sat_b), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomised run against the model.
        gen_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(99);
            if (r < 25) step(1'b0, 1'(($urandom_range(1))), 1'b0);
            else if (r < 27) step(1'(($urandom_range(1))), 1'(($urandom_range(1))), 1'b1);
            else if (r < 29) step(1'b1, 1'(($urandom_range(1))), 1'b0);
            else send($urandom_range(99) < 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
Receive-side companion to the team's degree-7 LFSR pattern generator (polynomial x^7 + x^1 + 1). It consumes the serial PRBS bitstream one qualified bit at a time and self-synchronises to it with no seed exchange. Once locked, it compares every bit against the predicted bit and counts bit errors. It declares loss of lock when errors exceed a threshold within a window. It sits at the far end of the serial test link in the BIST path.

Parameters:
DEGREE, 7, LFSR degree; history register length.
TAP, 1, middle tap exponent; prediction is b[n] = b[n-DEGREE] XOR b[n-DEGREE+TAP].
LOCK_CNT, 16, consecutive correct predictions required to declare lock.
WINDOW, 64, locked-mode observation window in accepted bits (power of two).
LOSS_THRESH, 8, errors within one window that force loss of lock.
CNT_WIDTH, 16, width of the saturating error counter.

Ports:
Clk_CI  in  1  clock; all state is on the rising edge.
Rst_RBI  in  1  asynchronous, active-low reset.
InValid_SI  in  1  InBit_DI is a valid stream bit this cycle (accept).
InBit_DI  in  1  received PRBS bit.
Clear_SI  in  1  synchronous clear: zero ErrCnt, return to HUNT.
Locked_SO  out  1  checker is in LOCKED state.
BitErr_SO  out  1  one-cycle pulse per detected bit error.
ErrCnt_DO  out  CNT_WIDTH  saturating count of errors since reset/clear.
ErrSat_SO  out  1  ErrCnt_DO has reached 2^CNT_WIDTH-1.

Behaviour:
- Interface: one clock. Rst_RBI is asynchronous, active-low. Reset forces all outputs to 0, state to HUNT, and history, fill, match, window and error counters to 0.
- H[DEGREE-1:0] is the history register; H[0] is the newest bit. Predicted bit P = H[DEGREE-1] XOR H[DEGREE-1-TAP].
- Bits are processed only on cycles with InValid_SI=1. Idle cycles change nothing, and gaps of any length are legal.
- HUNT:
  - Each accepted bit shifts into H. FillCnt increments up to DEGREE.
  - Once FillCnt==DEGREE, each accepted bit is compared with P.
  - On a match with H != 0, MatchCnt increments. On a mismatch, or when H==0, MatchCnt is cleared. The all-zero lockup stream must never lock.
  - When MatchCnt reaches LOCK_CNT, the state moves to LOCKED.
  - No errors are counted in HUNT.
- LOCKED:
  - Each accepted bit is compared with P, and P (not the received bit) is shifted into H, so a single-bit error counts exactly once.
  - On a mismatch: BitErr_SO=1 on the next cycle, ErrCnt increments (saturating), WinErr increments.
  - WinCnt counts accepted bits. When it wraps at WINDOW, WinErr is cleared.
  - If WinErr reaches LOSS_THRESH (including the current error), the state moves to HUNT. FillCnt, MatchCnt, WinCnt and WinErr are cleared. ErrCnt is kept.
- Latency: all outputs are registered.
  - BitErr_SO and ErrCnt_DO update on the edge after the accepting cycle.
  - Locked_SO rises on the edge that accepts the LOCK_CNT-th match, and falls on the edge that accepts the threshold error.
  - From reset with a clean stream, Locked_SO=1 after DEGREE+LOCK_CNT accepted bits.
- Clear_SI:
  - Zeroes ErrCnt, ErrSat, WinCnt, WinErr, FillCnt and MatchCnt, and moves to HUNT.
  - Clear wins over a simultaneous InValid_SI, and that bit is discarded.
  - BitErr_SO is 0 on the following cycle.
- Saturation: ErrCnt holds at all-ones and ErrSat_SO stays 1 until reset or Clear. BitErr_SO still pulses while saturated.
- Reset mid-operation: immediate return to the reset state, including while BitErr_SO is high.

Decomposition:
- Shared package prbs_pkg holds:
  - state enum {HUNT, LOCKED}
  - default DEGREE and TAP constants (shared with the generator)
  - helper constant for the all-ones error count
- One sub-module, prbs_sat_cnt: a parameterised-width saturating up-counter with inc, clr and sat outputs. It is used for ErrCnt; window counters stay inline.

Test Plan:
1. Reset with InValid_SI=0 -> Locked_SO=0, BitErr_SO=0, ErrCnt_DO=0, ErrSat_SO=0 for 10 cycles.
2. Clean PRBS7 from seed 1,0,0,0,0,0,0 (continuing 1,0,0,0,0,0,1,1,...) -> Locked_SO rises after the 23rd accepted bit. 254 further bits give ErrCnt_DO=0. Repeat with random InValid_SI gaps -> same lock point in accepted bits.
3. Locked, then invert one bit -> exactly one BitErr_SO pulse, ErrCnt_DO=1, Locked_SO stays 1. Two flips 30 bits apart -> ErrCnt_DO=2.
4. 300 accepted zero bits, then 300 accepted one bits -> Locked_SO never asserts, ErrCnt_DO=0.
5. Locked, 8 flipped bits within 64 bits -> Locked_SO falls on the 8th, ErrCnt_DO=8. A clean stream then relocks after 23 bits with ErrCnt_DO=8. 7 flips per window -> stays locked.
6. CNT_WIDTH=4, locked, 20 spaced errors -> ErrCnt_DO=15, ErrSat_SO=1. Clear_SI with InValid_SI=1 -> ErrCnt_DO=0, Locked_SO=0, bit discarded. Rst_RBI low mid-lock -> all outputs 0.
